sum_to_bcd: RTL



---
 rtl/sum_to_bcd_if.sv | 54 +++++
 rtl/sum_to_bcd.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sum_to_bcd_if.sv
// sum_to_bcd_if: handshake/data bundle between the adder-side requester and sum_to_bcd.
//   start  requester -> converter  request conversion of sum
//   sum    requester -> converter  binary value to convert (WIDTH bits)
//   busy   converter -> requester  conversion in progress
//   done   converter -> requester  one-cycle pulse when bcd is updated
//   bcd    converter -> requester  packed BCD result (4*DIGITS bits)
//   hex3..hex0 converter -> requester  active-low gfedcba segment codes, only with
//   SUM_TO_BCD_SEG_DECODE_EN defined.
interface sum_to_bcd_if #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic [WIDTH-1:0]      sum;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
`ifdef SUM_TO_BCD_SEG_DECODE_EN
  logic [6:0]            hex3;
  logic [6:0]            hex2;
  logic [6:0]            hex1;
  logic [6:0]            hex0;
`endif

  modport master (
    output start,
    output sum,
    input  busy,
    input  done,
    input  bcd
`ifdef SUM_TO_BCD_SEG_DECODE_EN
    ,
    input  hex3,
    input  hex2,
    input  hex1,
    input  hex0
`endif
  );

  modport slave (
    input  start,
    input  sum,
    output busy,
    output done,
    output bcd
`ifdef SUM_TO_BCD_SEG_DECODE_EN
    ,
    output hex3,
    output hex2,
    output hex1,
    output hex0
`endif
  );
endinterface

// File: rtl/sum_to_bcd.sv
// sum_to_bcd: iterative shift-and-add-3 (double dabble) converter for the 10-bit adder sum.
// One bit is processed per clock; a conversion takes 10 shift cycles plus one DONE cycle.
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous active-high reset; aborts any conversion in flight
//   bus    sum_to_bcd_if.slave: start/sum in, busy/done/bcd out (hex3..hex0 when enabled)
// Optional feature: define SUM_TO_BCD_SEG_DECODE_EN to add registered seven-segment
// outputs hex3..hex0 (active-low, gfedcba), updated one cycle after bcd.
module sum_to_bcd #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned DIGITS = 4
) (
  input logic        clk,
  input logic        reset,
  sum_to_bcd_if.slave bus
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]   scr_q, scr_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcdW-1:0]   adj;
  logic [BcdW-1:0]   shifted;

  always_comb begin
    adj = scr_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
    // Binary MSB shifts into the scratch LSB.
    shifted = {adj[BcdW-2:0], bin_q[WIDTH-1]};
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          bin_d   = bus.sum;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        scr_d = shifted;
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          bcd_d   = shifted;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      bin_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  // DONE lasts exactly one cycle, so the state itself is the done pulse.
  assign bus.busy = (state_q == StShift);
  assign bus.done = (state_q == StDone);
  assign bus.bcd  = bcd_q;

`ifdef SUM_TO_BCD_SEG_DECODE_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [6:0] hex3_q, hex2_q, hex1_q, hex0_q;

  // Registered from bcd_q, so the display follows bcd by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex3_q <= 7'b1000000;
      hex2_q <= 7'b1000000;
      hex1_q <= 7'b1000000;
      hex0_q <= 7'b1000000;
    end else begin
      hex3_q <= seg7(bcd_q[15:12]);
      hex2_q <= seg7(bcd_q[11:8]);
      hex1_q <= seg7(bcd_q[7:4]);
      hex0_q <= seg7(bcd_q[3:0]);
    end
  end

  assign bus.hex3 = hex3_q;
  assign bus.hex2 = hex2_q;
  assign bus.hex1 = hex1_q;
  assign bus.hex0 = hex0_q;
`endif

endmodule
